// File: rtl/xgmii_rx_link_fault_pkg.sv
// ---------------------------------------------------------------------------
// xgmii_rx_link_fault_pkg
// Shared constants, types and the per-column state-update function for the
// XGMII receive link-fault monitor.
//   - XGMII sequence ordered-set constants and local/remote fault codes
//   - fault_t        : fault-type encoding (NONE doubles as link OK)
//   - lf_state_t     : link-fault monitor state (last_type, counters, fault)
//   - col_step()     : applies one 32-bit column to the monitor state
// ---------------------------------------------------------------------------
package xgmii_rx_link_fault_pkg;

  localparam logic [7:0] XGMII_SEQ     = 8'h9C;
  localparam logic [7:0] LF_CODE       = 8'h01;
  localparam logic [7:0] RF_CODE       = 8'h02;
  localparam int         COL_LIMIT     = 128;
  localparam int         SEQ_THRESHOLD = 4;

  localparam int         COL_CNT_W   = 7;
  localparam int         SEQ_CNT_W   = 2;
  localparam logic [COL_CNT_W-1:0] COL_CNT_MAX = COL_CNT_W'(COL_LIMIT - 1);
  localparam logic [SEQ_CNT_W-1:0] SEQ_CNT_MAX = SEQ_CNT_W'(SEQ_THRESHOLD - 1);

  // FT_NONE is "no sequence seen" for last_type and "link OK" for link_fault.
  typedef enum logic [1:0] {
    FT_NONE   = 2'd0,
    FT_LOCAL  = 2'd1,
    FT_REMOTE = 2'd2
  } fault_t;

  typedef struct packed {
    fault_t                 last_type;
    logic [SEQ_CNT_W-1:0]   seq_cnt;
    logic [COL_CNT_W-1:0]   col_cnt;
    fault_t                 link_fault;
  } lf_state_t;

  localparam lf_state_t LF_STATE_RESET = '{
    last_type:  FT_NONE,
    seq_cnt:    '0,
    col_cnt:    '0,
    link_fault: FT_NONE
  };

  // One column of the link-fault state machine. The same function is chained
  // twice per cycle so column 1 sees the state left behind by column 0.
  function automatic lf_state_t col_step(input lf_state_t s,
                                         input logic      is_seq,
                                         input fault_t    seq_type);
    lf_state_t n;
    n = s;
    if (is_seq) begin
      n.col_cnt = '0;
      if (seq_type != s.last_type) begin
        n.last_type = seq_type;
        n.seq_cnt   = SEQ_CNT_W'(1);
      end else if (s.seq_cnt < SEQ_CNT_MAX) begin
        n.seq_cnt = s.seq_cnt + SEQ_CNT_W'(1);
      end else begin
        // Fourth consecutive same-type sequence: commit; seq_cnt stays at max
        // so every further sequence of this type keeps refreshing the fault.
        n.link_fault = seq_type;
      end
    end else if (s.col_cnt < COL_CNT_MAX) begin
      n.col_cnt = s.col_cnt + COL_CNT_W'(1);
    end else begin
      // 128th consecutive non-sequence column: link is clean again.
      n = LF_STATE_RESET;
    end
    return n;
  endfunction

endpackage

// File: rtl/xgmii_rx_link_fault_seq_detect.sv
// ---------------------------------------------------------------------------
// xgmii_seq_detect
// Combinational detector for one XGMII column (4 lanes). Flags a link-fault
// sequence ordered set (control on lane 0 only, 0x9C 00 00 code) and
// reports whether the code is local (0x01) or remote (0x02) fault.
//   i_col_data [31:0] : column bytes, byte 0 in [7:0]
//   i_col_ctrl [3:0]  : per-lane control bits, lane 0 in [0]
//   o_is_seq          : column is a local or remote fault sequence
//   o_seq_type        : FT_LOCAL / FT_REMOTE when o_is_seq, else FT_NONE
// ---------------------------------------------------------------------------
module xgmii_seq_detect
  import xgmii_rx_link_fault_pkg::*;
(
  input  logic [31:0] i_col_data,
  input  logic [3:0]  i_col_ctrl,
  output logic        o_is_seq,
  output fault_t      o_seq_type
);

  logic w_seq_header;

  assign w_seq_header = (i_col_ctrl == 4'b0001)
                     && (i_col_data[7:0]   == XGMII_SEQ)
                     && (i_col_data[15:8]  == 8'h00)
                     && (i_col_data[23:16] == 8'h00);

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave it unassigned and infer a latch.
    o_is_seq   = 1'b0;
    o_seq_type = FT_NONE;
    if (w_seq_header) begin
      if (i_col_data[31:24] == LF_CODE) begin
        o_is_seq   = 1'b1;
        o_seq_type = FT_LOCAL;
      end else if (i_col_data[31:24] == RF_CODE) begin
        o_is_seq   = 1'b1;
        o_seq_type = FT_REMOTE;
      end
    end
  end

endmodule

// File: rtl/xgmii_rx_link_fault.sv
// ---------------------------------------------------------------------------
// xgmii_rx_link_fault
// Receive-side link-fault monitor for a 10G reconciliation sublayer. Sits
// directly after the 10G PHY RX, watches both XGMII columns for local/remote
// fault sequences and maintains the link_fault state.
//   clk                  : PHY RX clock
//   rst                  : synchronous active-high reset
//   xgmii_rxd[63:0]      : RX data, column 0 = bytes 0-3, column 1 = 4-7
//   xgmii_rxc[7:0]       : RX control, one bit per byte
//   rx_block_lock        : PCS block lock; low forces local fault
//   rx_local_fault       : link_fault is LOCAL
//   rx_remote_fault      : link_fault is REMOTE
//   rx_link_ok           : link_fault is OK and block lock is up
//   tx_send_rf           : TX RS should send remote fault (we see LOCAL)
//   tx_send_idle         : TX RS should send idles only (we see REMOTE)
//   rx_fault_event_count : saturating count of OK-to-fault transitions
// All outputs are registered: one cycle from the causing input cycle.
// ---------------------------------------------------------------------------
module xgmii_rx_link_fault
  import xgmii_rx_link_fault_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  input  logic                  rx_block_lock,
  output logic                  rx_local_fault,
  output logic                  rx_remote_fault,
  output logic                  rx_link_ok,
  output logic                  tx_send_rf,
  output logic                  tx_send_idle,
  output logic [7:0]            rx_fault_event_count
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $error("xgmii_rx_link_fault: DATA_WIDTH must be 64");
  end
  if (CTRL_WIDTH * 8 != DATA_WIDTH) begin : g_bad_ctrl_width
    $error("xgmii_rx_link_fault: CTRL_WIDTH*8 must equal DATA_WIDTH");
  end

  logic      w_is_seq0;
  logic      w_is_seq1;
  fault_t    w_type0;
  fault_t    w_type1;
  lf_state_t w_state_col0;
  lf_state_t w_state_next;
  logic      w_fault_event;

  lf_state_t r_state;
  logic      r_local_fault;
  logic      r_remote_fault;
  logic      r_link_ok;
  logic [7:0] r_event_count;

  xgmii_seq_detect u_seq_detect_col0 (
    .i_col_data (xgmii_rxd[31:0]),
    .i_col_ctrl (xgmii_rxc[3:0]),
    .o_is_seq   (w_is_seq0),
    .o_seq_type (w_type0)
  );

  xgmii_seq_detect u_seq_detect_col1 (
    .i_col_data (xgmii_rxd[63:32]),
    .i_col_ctrl (xgmii_rxc[7:4]),
    .o_is_seq   (w_is_seq1),
    .o_seq_type (w_type1)
  );

  // Column 0 first, then column 1 on top of column 0's result.
  assign w_state_col0 = col_step(r_state, w_is_seq0, w_type0);

  always_comb begin
    w_state_next = col_step(w_state_col0, w_is_seq1, w_type1);
    // Without block lock the column content is meaningless: hold local fault
    // and throw away any partial sequence/idle counting.
    if (!rx_block_lock) begin
      w_state_next            = LF_STATE_RESET;
      w_state_next.link_fault = FT_LOCAL;
    end
  end

  // Compared against the registered value, so at most one event per cycle.
  assign w_fault_event = (r_state.link_fault == FT_NONE)
                      && (w_state_next.link_fault != FT_NONE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples
    // the pre-edge values and the update order inside the block is irrelevant.
    if (rst) begin
      r_state        <= LF_STATE_RESET;
      r_event_count  <= '0;
      r_local_fault  <= 1'b0;
      r_remote_fault <= 1'b0;
      r_link_ok      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_local_fault  <= (w_state_next.link_fault == FT_LOCAL);
      r_remote_fault <= (w_state_next.link_fault == FT_REMOTE);
      r_link_ok      <= (w_state_next.link_fault == FT_NONE) && rx_block_lock;
      if (w_fault_event && (r_event_count != 8'hFF)) begin
        r_event_count <= r_event_count + 8'd1;
      end
    end
  end

  assign rx_local_fault       = r_local_fault;
  assign rx_remote_fault      = r_remote_fault;
  assign rx_link_ok           = r_link_ok;
  assign tx_send_rf           = r_local_fault;
  assign tx_send_idle         = r_remote_fault;
  assign rx_fault_event_count = r_event_count;

endmodule
